total_alu_mc: RTL

- Parametrised, multi-cycle successor to the 32-bit ALU top.
- Integer datapath with WIDTH-bit operands:
  - single-cycle logic, arithmetic and shift operations;
  - iterative unsigned multiply (MULTU) and divide (DIVU) into internal HI/LO registers;
  - MFHI/MFLO readback.
- Adds a start/busy/done handshake, logical right shift and divide, none of which the previous generation has.
- Sits between the instruction decode (Signal = funct field) and the register-file writeback.

---
 rtl/total_alu_mc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/total_alu_mc.sv
// total_alu_mc: multi-cycle ALU with shift-add MULTU, restoring DIVU and HI/LO readback.
// Optional: define OVF_DETECT_EN to add the registered signed-overflow flag output ovf.
module total_alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] Output,
`ifdef OVF_DETECT_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0]   hi, lo, opnd;
    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic [2*WIDTH-1:0] acc, mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last, is_mul, is_div, div_ge;

    assign busy   = (state != IDLE);
    assign accept = start && !busy;
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign is_mul = (Signal == F_MULTU);
    assign is_div = (Signal == F_DIVU);
    assign sum    = dataA + dataB;
    assign diff   = dataA - dataB;

    // Multiply: acc = {partial product, remaining multiplier bits}, one bit retired per cycle.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; remainder < divisor keeps
    // the WIDTH+1-bit difference's msb a valid borrow flag.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = !div_diff[WIDTH];
    assign div_next  = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    always_comb begin
        alu_res = '0;
        case (Signal)
            F_AND:   alu_res = dataA & dataB;
            F_OR:    alu_res = dataA | dataB;
            F_ADD:   alu_res = sum;
            F_SUB:   alu_res = diff;
            F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            F_SLL:   alu_res = dataA << dataB[SHAMT_W-1:0];
            F_SRL:   alu_res = dataA >> dataB[SHAMT_W-1:0];
            F_MFHI:  alu_res = hi;
            F_MFLO:  alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_next = MUL;
                end else if (accept && is_div) begin
                    state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Output <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (is_mul) begin
                            acc  <= {{WIDTH{1'b0}}, dataB};
                            opnd <= dataA;
                        end else if (is_div) begin
                            acc  <= {{WIDTH{1'b0}}, dataA};
                            opnd <= dataB;
                        end else begin
                            Output <= alu_res;
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi   <= mul_next[2*WIDTH-1:WIDTH];
                        lo   <= mul_next[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi   <= div_next[2*WIDTH-1:WIDTH];
                        lo   <= div_next[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OVF_DETECT_EN
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (Signal == F_ADD) begin
            alu_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);
        end else if (Signal == F_SUB) begin
            alu_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (diff[WIDTH-1] != dataA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= alu_ovf;
        end
    end
`endif

endmodule
